// File: rtl/parking_slot_arbiter.sv
// parking_slot_arbiter
// Shares one flat-occupancy table among G gate controllers. A requesting gate
// is chosen (PWD requests first, then round-robin), its entry/exit operation
// is applied atomically to the table, and the result is returned over a
// four-phase req/ack handshake.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   req         per-gate request level, held until the matching ack is seen
//   op          per-gate operation: 0 = entry (occupy), 1 = exit (release)
//   pwd_flag    per-gate PWD priority qualifier
//   flat_number packed flat numbers, gate g uses [g*FW +: FW]
//   ack         per-gate acknowledge level (at most one bit high)
//   ok          per-gate result, valid while the matching ack is high
//   busy        high whenever the FSM is not idle
//   occ_map     occupancy table, bit f = 1 means flat f is occupied
//   occ_count   number of set bits in occ_map
module parking_slot_arbiter #(
    parameter int N  = 10,
    parameter int G  = 2,
    parameter int FW = $clog2(N) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [G-1:0]            req,
    input  logic [G-1:0]            op,
    input  logic [G-1:0]            pwd_flag,
    input  logic [G*FW-1:0]         flat_number,
    output logic [G-1:0]            ack,
    output logic [G-1:0]            ok,
    output logic                    busy,
    output logic [N:0]              occ_map,
    output logic [$clog2(N+2)-1:0]  occ_count
);

    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int CW = $clog2(N + 2);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_q, last_d;
    logic [GW-1:0]   win_q, win_d;
    logic            op_q, op_d;
    logic [FW-1:0]   flat_q, flat_d;
    logic [G-1:0]    ack_q, ack_d;
    logic [G-1:0]    ok_q, ok_d;
    logic [N:0]      occ_map_q, occ_map_d;
    logic [CW-1:0]   occ_count_q, occ_count_d;

    logic [G-1:0]    cand;
    logic            found;
    logic [N:0]      flat_sel;
    logic [G-1:0]    win_hot;
    logic            req_win;
    logic            occ_hit;
    logic            in_range;
    logic            accept;

    // State register; reset leaves gate 0 first in round-robin order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= GW'(G - 1);
            win_q       <= '0;
            op_q        <= 1'b0;
            flat_q      <= '0;
            ack_q       <= '0;
            ok_q        <= '0;
            occ_map_q   <= '0;
            occ_count_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            op_q        <= op_d;
            flat_q      <= flat_d;
            ack_q       <= ack_d;
            ok_q        <= ok_d;
            occ_map_q   <= occ_map_d;
            occ_count_q <= occ_count_d;
        end
    end

    // Arbitration, check-and-update and handshake sequencing
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        op_d        = op_q;
        flat_d      = flat_q;
        ack_d       = ack_q;
        ok_d        = ok_q;
        occ_map_d   = occ_map_q;
        occ_count_d = occ_count_q;
        cand        = '0;
        found       = 1'b0;
        flat_sel    = '0;
        win_hot     = '0;
        accept      = 1'b0;

        // One-hot decode of the latched flat; an out-of-range flat decodes
        // to all zeros, which doubles as the range check.
        for (int f = 0; f <= N; f++) begin
            if (flat_q == FW'(f)) flat_sel[f] = 1'b1;
        end
        for (int g = 0; g < G; g++) begin
            if (win_q == GW'(g)) win_hot[g] = 1'b1;
        end
        req_win  = |(req & win_hot);
        occ_hit  = |(occ_map_q & flat_sel);
        in_range = |flat_sel;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    cand = (|(req & pwd_flag)) ? (req & pwd_flag) : req;
                    // Scan gates in order last+1, last+2, ... and take the
                    // first candidate.
                    for (int i = 1; i <= G; i++) begin
                        for (int g = 0; g < G; g++) begin
                            if (!found && cand[g] && (g == (int'(last_q) + i) % G)) begin
                                found  = 1'b1;
                                win_d  = GW'(g);
                                last_d = GW'(g);
                                op_d   = op[g];
                                flat_d = flat_number[g*FW +: FW];
                            end
                        end
                    end
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (in_range) begin
                    if (!op_q && !occ_hit) begin
                        accept      = 1'b1;
                        occ_map_d   = occ_map_q | flat_sel;
                        occ_count_d = occ_count_q + CW'(1);
                    end else if (op_q && occ_hit) begin
                        accept      = 1'b1;
                        occ_map_d   = occ_map_q & ~flat_sel;
                        occ_count_d = occ_count_q - CW'(1);
                    end
                end
                ack_d   = win_hot;
                ok_d    = accept ? win_hot : '0;
                state_d = RESP;
            end
            RESP: begin
                if (!req_win) begin
                    ack_d   = '0;
                    ok_d    = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack       = ack_q;
    assign ok        = ok_q;
    assign busy      = (state_q != IDLE);
    assign occ_map   = occ_map_q;
    assign occ_count = occ_count_q;

endmodule

// File: tb/tb_parking_slot_arbiter.sv
// Directed testbench for parking_slot_arbiter (N = 10, G = 2).
module tb_parking_slot_arbiter;

    localparam int N  = 10;
    localparam int G  = 2;
    localparam int FW = 5;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [G-1:0]      req;
    logic [G-1:0]      op;
    logic [G-1:0]      pwd_flag;
    logic [G*FW-1:0]   flat_number;
    logic [G-1:0]      ack;
    logic [G-1:0]      ok;
    logic              busy;
    logic [N:0]        occ_map;
    logic [CW-1:0]     occ_count;

    int   checkCount = 0;
    int   errorCount = 0;
    bit   seen;
    int   expG;
    logic [1:0] expAck;
    int   cnt [2];

    parking_slot_arbiter #(.N(N), .G(G), .FW(FW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .op          (op),
        .pwd_flag    (pwd_flag),
        .flat_number (flat_number),
        .ack         (ack),
        .ok          (ok),
        .busy        (busy),
        .occ_map     (occ_map),
        .occ_count   (occ_count)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Wait a bounded number of cycles for ack on one gate
    task automatic waitAck(input int gate, output bit got);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (ack[gate] === 1'b1) got = 1'b1;
        end
    endtask

    // One complete handshake on a single gate with the expected result
    task automatic applyStimulus(input int gate, input bit opv, input int flatv, input bit pwdv,
                                 input bit expOk, input string tag);
        bit got;
        op[gate]                   = opv;
        pwd_flag[gate]             = pwdv;
        flat_number[gate*FW +: FW] = FW'(flatv);
        req[gate]                  = 1'b1;
        waitAck(gate, got);
        checkOutput({tag, "_ack"}, 32'(got), 32'd1);
        checkOutput({tag, "_ok"}, 32'(ok[gate]), 32'(expOk));
        req[gate] = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_ackfall"}, 32'(ack), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        req         = '0;
        op          = '0;
        pwd_flag    = '0;
        flat_number = '0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst_occ_map", 32'(occ_map), 32'h0);
        checkOutput("rst_occ_count", 32'(occ_count), 32'd0);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_ok", 32'(ok), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);

        // Gate 0 entry on flat 3 with explicit latency checks
        $display("[TB] gate0 entry flat 3");
        op[0]          = 1'b0;
        flat_number[4:0] = 5'd3;
        req[0]         = 1'b1;
        @(negedge clk);
        checkOutput("t1_ack_early", 32'(ack), 32'd0);
        checkOutput("t1_busy_check", 32'(busy), 32'd1);
        checkOutput("t1_map_early", 32'(occ_map), 32'h0);
        @(negedge clk);
        checkOutput("t1_ack", 32'(ack), 32'd1);
        checkOutput("t1_ok", 32'(ok), 32'd1);
        checkOutput("t1_map", 32'(occ_map), 32'h008);
        checkOutput("t1_count", 32'(occ_count), 32'd1);
        checkOutput("t1_busy_resp", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("t1_ack_hold", 32'(ack), 32'd1);
        checkOutput("t1_busy_hold", 32'(busy), 32'd1);
        req[0] = 1'b0;
        @(negedge clk);
        checkOutput("t1_ack_fall", 32'(ack), 32'd0);
        checkOutput("t1_ok_fall", 32'(ok), 32'd0);
        checkOutput("t1_busy_fall", 32'(busy), 32'd0);

        // Duplicate entry refused, then exit accepted
        $display("[TB] gate1 duplicate entry and exit on flat 3");
        applyStimulus(1, 1'b0, 3, 1'b0, 1'b0, "t2_dup");
        checkOutput("t2_dup_map", 32'(occ_map), 32'h008);
        checkOutput("t2_dup_count", 32'(occ_count), 32'd1);
        applyStimulus(1, 1'b1, 3, 1'b0, 1'b1, "t2_exit");
        checkOutput("t2_exit_map", 32'(occ_map), 32'h000);
        checkOutput("t2_exit_count", 32'(occ_count), 32'd0);

        // Simultaneous requests: PWD gate 1 wins over gate 0
        $display("[TB] PWD priority");
        op          = 2'b00;
        pwd_flag    = 2'b10;
        flat_number = {5'd2, 5'd1};
        req         = 2'b11;
        waitAck(1, seen);
        checkOutput("t3_g1_seen", 32'(seen), 32'd1);
        checkOutput("t3_g1_ack", 32'(ack), 32'b10);
        checkOutput("t3_g1_ok", 32'(ok), 32'b10);
        req[1] = 1'b0;
        waitAck(0, seen);
        checkOutput("t3_g0_seen", 32'(seen), 32'd1);
        checkOutput("t3_g0_ack", 32'(ack), 32'b01);
        checkOutput("t3_g0_ok", 32'(ok), 32'b01);
        req[0] = 1'b0;
        @(negedge clk);
        checkOutput("t3_ack_fall", 32'(ack), 32'd0);
        checkOutput("t3_map", 32'(occ_map), 32'h006);
        checkOutput("t3_count", 32'(occ_count), 32'd2);
        pwd_flag = 2'b00;

        // Continuous requests from both gates; gate 0 was served last, so
        // gate 1 leads and grants then alternate.
        $display("[TB] round-robin alternation");
        cnt[0]      = 0;
        cnt[1]      = 0;
        op          = 2'b00;
        flat_number = {5'd5, 5'd4};
        req         = 2'b11;
        for (int k = 0; k < 6; k++) begin
            expG   = (k % 2 == 0) ? 1 : 0;
            expAck = (expG == 1) ? 2'b10 : 2'b01;
            seen   = 1'b0;
            for (int c = 0; c < 12 && !seen; c++) begin
                @(negedge clk);
                if (ack !== 2'b00) seen = 1'b1;
            end
            checkOutput($sformatf("t4_grant%0d_seen", k), 32'(seen), 32'd1);
            checkOutput($sformatf("t4_grant%0d_ack", k), 32'(ack), 32'(expAck));
            checkOutput($sformatf("t4_grant%0d_ok", k), 32'(ok), 32'(expAck));
            req[expG] = 1'b0;
            @(negedge clk);
            cnt[expG]++;
            if (cnt[expG] < 3) begin
                flat_number[expG*FW +: FW] = FW'(4 + expG + 2 * cnt[expG]);
                req[expG] = 1'b1;
            end
        end
        checkOutput("t4_map", 32'(occ_map), 32'h3F6);
        checkOutput("t4_count", 32'(occ_count), 32'd8);

        // Out-of-range flat and exit on a free flat are both refused
        $display("[TB] refusals");
        applyStimulus(0, 1'b0, 11, 1'b0, 1'b0, "t5_range");
        checkOutput("t5_range_map", 32'(occ_map), 32'h3F6);
        applyStimulus(0, 1'b1, 3, 1'b0, 1'b0, "t5_exitfree");
        checkOutput("t5_exitfree_count", 32'(occ_count), 32'd8);

        // Fill remaining flats 0, 3, 10
        $display("[TB] fill table");
        applyStimulus(0, 1'b0, 0, 1'b0, 1'b1, "t6_f0");
        applyStimulus(1, 1'b0, 3, 1'b0, 1'b1, "t6_f3");
        applyStimulus(0, 1'b0, 10, 1'b0, 1'b1, "t6_f10");
        checkOutput("t6_map", 32'(occ_map), 32'h7FF);
        checkOutput("t6_count", 32'(occ_count), 32'd11);
        applyStimulus(1, 1'b0, 10, 1'b0, 1'b0, "t6_full");
        checkOutput("t6_full_count", 32'(occ_count), 32'd11);

        // Reset while a request sits in CHECK
        $display("[TB] reset during CHECK");
        op[1]             = 1'b1;
        flat_number[9:5]  = 5'd5;
        req[1]            = 1'b1;
        @(negedge clk);
        checkOutput("t7_busy_check", 32'(busy), 32'd1);
        checkOutput("t7_ack_check", 32'(ack), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("t7_rst_map", 32'(occ_map), 32'h0);
        checkOutput("t7_rst_count", 32'(occ_count), 32'd0);
        checkOutput("t7_rst_ack", 32'(ack), 32'd0);
        checkOutput("t7_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        req   = 2'b00;
        checkOutput("t7_rst_ack_hold", 32'(ack), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t7_post_ack", 32'(ack), 32'd0);
        checkOutput("t7_post_map", 32'(occ_map), 32'h0);
        checkOutput("t7_post_count", 32'(occ_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
